// File: rtl/input_controller_if.sv
// -----------------------------------------------------------------------------
// input_controller_if
//   Groups the byte-stream handshake and the word-memory write bus of the
//   input controller.
//
//   Stream side : tdata_in, tvalid_in, tlast_in (into the controller),
//                 tready_out (out of the controller)
//   Write side  : wr_addr, wr_data, wr_en (out of the controller),
//                 wr_ready_in (into the controller)
//   Status      : frame_err_out, a one-cycle pulse on a short frame
//
//   master : controller view (drives tready_out, the write request, status)
//   slave  : environment view (byte source and word memory)
// -----------------------------------------------------------------------------
interface input_controller_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 80
) ();

    logic [7:0]            tdata_in;
    logic                  tvalid_in;
    logic                  tlast_in;
    logic                  tready_out;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  wr_ready_in;

    logic                  frame_err_out;

    modport master (
        input  tdata_in,
        input  tvalid_in,
        input  tlast_in,
        output tready_out,
        output wr_addr,
        output wr_data,
        output wr_en,
        input  wr_ready_in,
        output frame_err_out
    );

    modport slave (
        output tdata_in,
        output tvalid_in,
        output tlast_in,
        input  tready_out,
        input  wr_addr,
        input  wr_data,
        input  wr_en,
        output wr_ready_in,
        input  frame_err_out
    );

endinterface

// File: rtl/input_controller.sv
// -----------------------------------------------------------------------------
// input_controller
//   Packs NBYTES consecutive stream bytes into one DATA_WIDTH word (first byte
//   in the MSBs) and writes each word into the shared word memory at
//   0, ADDR_STEP, 2*ADDR_STEP, ... LAST_ADDR, then wraps to 0. A frame that
//   ends (tlast) before NBYTES bytes is dropped and flagged on frame_err_out.
//
//   Ports
//     clk_in  : single clock, rising edge
//     rst_in  : asynchronous, active-high reset
//     bus     : input_controller_if.master
//               stream  tdata_in / tvalid_in / tlast_in / tready_out
//               memory  wr_addr / wr_data / wr_en / wr_ready_in
//               status  frame_err_out
//
//   State table
//     state   | meaning
//     --------+--------------------------------------------------------------
//     COLLECT | accepting bytes into the packing register (tready_out = 1)
//     WRITE   | word complete, write request held until wr_ready_in
// -----------------------------------------------------------------------------
module input_controller #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 80,
    parameter int                    ADDR_STEP  = 4,
    parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = 8'h0C
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input_controller_if.master   bus
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(ADDR_STEP);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        WRITE   = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [CNT_W-1:0]      byte_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  frame_err_q;

    logic                  ready_c;
    logic                  wr_en_c;
    logic                  xfer_c;
    logic                  word_done_c;
    logic                  short_frame_c;
    logic                  wr_done_c;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        ready_c       = 1'b0;
        wr_en_c       = 1'b0;
        xfer_c        = 1'b0;
        word_done_c   = 1'b0;
        short_frame_c = 1'b0;
        wr_done_c     = 1'b0;

        case (state_q)
            COLLECT: begin
                // tready is forced low while reset is held so the source
                // never sees a transfer that the frozen flops cannot take.
                ready_c = ~rst_in;
                xfer_c  = bus.tvalid_in & ready_c;
                if (xfer_c) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        // tlast on the final byte is a normal frame end
                        word_done_c = 1'b1;
                        state_d     = WRITE;
                    end else if (bus.tlast_in) begin
                        short_frame_c = 1'b1;
                    end
                end
            end
            WRITE: begin
                wr_en_c = 1'b1;
                if (bus.wr_ready_in) begin
                    wr_done_c = 1'b1;
                    state_d   = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte counter, packing register, address counter, error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            byte_cnt_q  <= '0;
            addr_cnt_q  <= '0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= short_frame_c;

            if (xfer_c) begin
                // Constant lane indices keep the byte steering a plain mux;
                // lane b holds byte b of the word, MSB-first.
                for (int b = 0; b < NBYTES; b++) begin
                    if (byte_cnt_q == CNT_W'(b)) begin
                        data_q[DATA_WIDTH-1-8*b -: 8] <= bus.tdata_in;
                    end
                end

                if (word_done_c || short_frame_c) begin
                    byte_cnt_q <= '0;
                end else begin
                    byte_cnt_q <= byte_cnt_q + 1'b1;
                end
            end

            if (wr_done_c) begin
                if (addr_cnt_q == LAST_ADDR) begin
                    addr_cnt_q <= '0;
                end else begin
                    addr_cnt_q <= addr_cnt_q + STEP;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. wr_data is the packing register itself: it cannot move in
    // WRITE because no byte is accepted there.
    // ------------------------------------------------------------------
    assign bus.tready_out    = ready_c;
    assign bus.wr_en         = wr_en_c;
    assign bus.wr_addr       = addr_cnt_q;
    assign bus.wr_data       = data_q;
    assign bus.frame_err_out = frame_err_q;

endmodule

// File: tb/tb_input_controller.sv
module tb_input_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    input_controller_if bus ();

    input_controller dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: list of bytes collected so far, pending word, writes done
    logic [7:0]  m_bytes[$];
    bit          m_write;
    logic [79:0] m_word;
    bit          m_err;
    int          m_nwr;

    // observations of the DUT
    int          dut_writes;
    int          dut_err_pulses;
    int          dut_trdy_low;
    logic [79:0] dut_last_data;
    logic [7:0]  dut_last_addr;

    // stimulus queues
    logic [7:0]  sq[$];
    bit          lq[$];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] pack_bytes();
        logic [79:0] w = '0;
        foreach (m_bytes[i]) w = {w[71:0], m_bytes[i]};
        return w;
    endfunction

    function automatic logic [7:0] exp_addr();
        return 8'((m_nwr % 4) * 4);
    endfunction

    task automatic model_reset();
        m_bytes.delete();
        m_write = 0;
        m_err   = 0;
        m_nwr   = 0;
        m_word  = '0;
    endtask

    task automatic clr_stats();
        dut_writes     = 0;
        dut_err_pulses = 0;
        dut_trdy_low   = 0;
        dut_last_data  = '0;
        dut_last_addr  = '0;
    endtask

    // One clock cycle: entered and left just after a falling edge.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit rdy,
                        output bit accepted);
        bus.tvalid_in   = v;
        bus.tdata_in    = d;
        bus.tlast_in    = l;
        bus.wr_ready_in = rdy;
        #1;
        chk("tready",    80'(bus.tready_out),    80'(!m_write));
        chk("wr_en",     80'(bus.wr_en),         80'(m_write));
        chk("frame_err", 80'(bus.frame_err_out), 80'(m_err));
        if (m_write) begin
            chk("wr_addr", 80'(bus.wr_addr), 80'(exp_addr()));
            chk("wr_data", bus.wr_data, m_word);
        end
        if (bus.wr_en && rdy) begin
            dut_writes++;
            dut_last_data = bus.wr_data;
            dut_last_addr = bus.wr_addr;
        end
        if (bus.frame_err_out) dut_err_pulses++;
        if (!bus.tready_out)   dut_trdy_low++;
        accepted = v && !m_write;
        @(posedge clk);
        m_err = 0;
        if (!m_write) begin
            if (v) begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 10) begin
                    m_word = pack_bytes();
                    m_bytes.delete();
                    m_write = 1;
                end else if (l) begin
                    m_bytes.delete();
                    m_err = 1;
                end
            end
        end else if (rdy) begin
            m_write = 0;
            m_nwr++;
        end
        @(negedge clk);
    endtask

    task automatic run_stream(input int gap_pct, input int rdy_pct, input int max_cyc);
        int n = 0;
        bit acc;
        bit v;
        bit rdy;
        while (sq.size() > 0 && n < max_cyc) begin
            v   = ($urandom_range(99) >= gap_pct);
            rdy = ($urandom_range(99) < rdy_pct);
            if (v) begin
                step(1'b1, sq[0], lq[0], rdy, acc);
                if (acc) begin
                    void'(sq.pop_front());
                    void'(lq.pop_front());
                end
            end else begin
                step(1'b0, 8'($urandom), 1'($urandom), rdy, acc);
            end
            n++;
        end
        chk("stream_timeout", 80'(sq.size()), 80'd0);
        sq.delete();
        lq.delete();
    endtask

    task automatic drain(input int rdy_pct, input int max_cyc);
        int n = 0;
        bit acc;
        while (m_write && n < max_cyc) begin
            step(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(99) < rdy_pct), acc);
            n++;
        end
        chk("drain_timeout", 80'(m_write), 80'd0);
    endtask

    task automatic push_byte(input logic [7:0] d, input bit l);
        sq.push_back(d);
        lq.push_back(l);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.tvalid_in   = 1'b0;
        bus.tdata_in    = 8'h00;
        bus.tlast_in    = 1'b0;
        bus.wr_ready_in = 1'b0;
        #1;
        chk("rst_tready",    80'(bus.tready_out),    80'd0);
        chk("rst_wr_en",     80'(bus.wr_en),         80'd0);
        chk("rst_wr_addr",   80'(bus.wr_addr),       80'd0);
        chk("rst_wr_data",   bus.wr_data,            80'd0);
        chk("rst_frame_err", 80'(bus.frame_err_out), 80'd0);
        model_reset();
        clr_stats();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        bus.tvalid_in   = 1'b0;
        bus.tdata_in    = 8'h00;
        bus.tlast_in    = 1'b0;
        bus.wr_ready_in = 1'b0;
        @(negedge clk);

        // 1: ten bytes 01..0A back-to-back
        do_reset();
        for (int i = 1; i <= 10; i++) push_byte(8'(i), 1'b0);
        run_stream(0, 100, 50);
        drain(100, 20);
        chk("s1_writes", 80'(dut_writes), 80'd1);
        chk("s1_data", dut_last_data, 80'h0102030405060708090A);
        chk("s1_addr", 80'(dut_last_addr), 80'h00);
        chk("s1_trdy_low", 80'(dut_trdy_low), 80'd1);

        // 2: five words, address wrap
        do_reset();
        for (int n = 1; n <= 5; n++)
            for (int i = 0; i < 10; i++) push_byte(8'(n), 1'b0);
        run_stream(0, 100, 200);
        drain(100, 20);
        chk("s2_writes", 80'(dut_writes), 80'd5);
        chk("s2_addr", 80'(dut_last_addr), 80'h00);
        chk("s2_data", dut_last_data, {10{8'h05}});

        // 3: short frame then a full word
        do_reset();
        for (int i = 0; i < 4; i++) push_byte(8'($urandom), (i == 3));
        for (int i = 0; i < 10; i++) push_byte(8'(8'hA0 + i), 1'b0);
        run_stream(0, 100, 100);
        drain(100, 20);
        chk("s3_err_pulses", 80'(dut_err_pulses), 80'd1);
        chk("s3_writes", 80'(dut_writes), 80'd1);
        chk("s3_addr", 80'(dut_last_addr), 80'h00);
        chk("s3_data", dut_last_data, 80'hA0A1A2A3A4A5A6A7A8A9);

        // 4: write back-pressure for 5 cycles
        do_reset();
        for (int i = 0; i < 10; i++) push_byte(8'($urandom), 1'b0);
        run_stream(0, 100, 50);
        for (int i = 0; i < 5; i++) step(1'($urandom), 8'($urandom), 1'($urandom), 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        chk("s4_writes", 80'(dut_writes), 80'd1);
        chk("s4_trdy_low", 80'(dut_trdy_low), 80'd6);
        for (int i = 0; i < 10; i++) push_byte(8'($urandom), 1'b0);
        run_stream(0, 100, 50);
        drain(100, 20);
        chk("s4_next_addr", 80'(dut_last_addr), 80'h04);

        // 5: gappy tvalid
        do_reset();
        for (int i = 1; i <= 10; i++) push_byte(8'(i), 1'b0);
        run_stream(50, 100, 500);
        drain(100, 20);
        chk("s5_writes", 80'(dut_writes), 80'd1);
        chk("s5_data", dut_last_data, 80'h0102030405060708090A);

        // 6: reset mid-word at address 0x08
        do_reset();
        for (int i = 0; i < 20; i++) push_byte(8'($urandom), 1'b0);
        run_stream(0, 100, 100);
        drain(100, 20);
        chk("s6_pre_addr", 80'(exp_addr()), 80'h08);
        for (int i = 0; i < 6; i++) push_byte(8'hEE, 1'b0);
        run_stream(0, 100, 50);
        do_reset();
        for (int i = 0; i < 10; i++) push_byte(8'(8'h30 + i), 1'b0);
        run_stream(0, 100, 50);
        drain(100, 20);
        chk("s6_writes", 80'(dut_writes), 80'd1);
        chk("s6_addr", 80'(dut_last_addr), 80'h00);
        chk("s6_data", dut_last_data, 80'h30313233343536373839);

        // random soak: gaps, short frames, memory stalls
        do_reset();
        for (int i = 0; i < 300; i++) push_byte(8'($urandom), ($urandom_range(24) == 0));
        run_stream(30, 60, 8000);
        drain(60, 200);
        chk("soak_writes", 80'(dut_writes), 80'(m_nwr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
